// File: rtl/ov5640_reg_config.sv
// OV5640 power-up register sequencer: walks the register table, formats SCCB write
// words, drives the write engine handshake with NACK retry and delay-entry support.
module ov5640_reg_config #(
    parameter logic [7:0]  DEV_ADDR   = 8'h78,
    parameter int unsigned LUT_SIZE   = 252,
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned INIT_DELAY = 2000,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned DELAY_UNIT = 1000
) (
    input  logic             clock_i2c,
    input  logic             camera_rst,
    output logic [IDX_W-1:0] lut_index,
    input  logic [23:0]      lut_data,
    output logic [31:0]      i2c_data,
    output logic             start,
    input  logic             tr_end,
    input  logic             ack,
    output logic             config_done,
    output logic             config_err,
    output logic [IDX_W-1:0] err_index
);

    localparam int unsigned INIT_W = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES);
    localparam int unsigned DLY_W  = $clog2(255 * DELAY_UNIT + 1);
    localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        WAIT_INIT, FETCH, CHECK, DELAY, LOAD, XFER, EVAL, NEXT, DONE, ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  init_q, init_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               ack_q, ack_d;
    logic [IDX_W-1:0]   lut_index_d, err_index_d;
    logic [31:0]        i2c_data_d;
    logic               config_done_d, config_err_d;

    always_ff @(posedge clock_i2c) begin
        if (camera_rst) begin
            state_q     <= WAIT_INIT;
            init_q      <= '0;
            gap_q       <= '0;
            dly_q       <= '0;
            retry_q     <= '0;
            ack_q       <= 1'b0;
            lut_index   <= '0;
            err_index   <= '0;
            i2c_data    <= '0;
            config_done <= 1'b0;
            config_err  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            gap_q       <= gap_d;
            dly_q       <= dly_d;
            retry_q     <= retry_d;
            ack_q       <= ack_d;
            lut_index   <= lut_index_d;
            err_index   <= err_index_d;
            i2c_data    <= i2c_data_d;
            config_done <= config_done_d;
            config_err  <= config_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_d        = init_q;
        gap_d         = gap_q;
        dly_d         = dly_q;
        retry_d       = retry_q;
        ack_d         = ack_q;
        lut_index_d   = lut_index;
        err_index_d   = err_index;
        i2c_data_d    = i2c_data;
        config_done_d = config_done;
        config_err_d  = config_err;
        start         = 1'b0;

        case (state_q)
            WAIT_INIT: begin
                if (init_q == INIT_W'(INIT_DELAY - 1)) state_d = FETCH;
                else init_d = init_q + 1'b1;
            end
            FETCH: state_d = CHECK;
            CHECK: begin
                if (lut_data[23:8] == 16'hFFFF) begin
                    if (lut_data[7:0] == 8'd0) begin
                        state_d = NEXT;
                    end else begin
                        dly_d   = DLY_W'(lut_data[7:0] * DELAY_UNIT);
                        state_d = DELAY;
                    end
                end else begin
                    i2c_data_d = {DEV_ADDR, lut_data};
                    retry_d    = '0;
                    gap_d      = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = XFER;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            XFER: begin
                start = 1'b1;
                // gap counter is reused to blank tr_end during the first two cycles
                if (gap_q < GAP_W'(2)) begin
                    gap_d = gap_q + 1'b1;
                end else if (tr_end) begin
                    ack_d   = ack;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (!ack_q) begin
                    state_d = NEXT;
                end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    gap_d   = '0;
                    state_d = LOAD;
                end else begin
                    config_err_d = 1'b1;
                    err_index_d  = lut_index;
                    state_d      = ERROR;
                end
            end
            DELAY: begin
                dly_d = dly_q - 1'b1;
                if (dly_q == DLY_W'(1)) state_d = NEXT;
            end
            NEXT: begin
                if (lut_index == IDX_W'(LUT_SIZE - 1)) begin
                    config_done_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    lut_index_d = lut_index + 1'b1;
                    state_d     = FETCH;
                end
            end
            DONE, ERROR: ;
            default: state_d = WAIT_INIT;
        endcase
    end

endmodule
